// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit majority sampling, parity/stop checks.
// Optional macro UART_RX_SYNC_EN adds a two-flop synchronizer on RX_IN.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);
    localparam int unsigned PRE_W = 6;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [PRE_W-1:0]      pre_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_fail;
    logic                  stp_fail;
    logic                  samp0;
    logic                  samp1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rx;

    logic [PRE_W-1:0]      pre_sel;
    logic [CNT_W-1:0]      last_cnt;
    logic [CNT_W-1:0]      mid_cnt;
    logic [CNT_W-1:0]      lo_cnt;
    logic [CNT_W-1:0]      hi_cnt;
    logic                  wrap;
    logic                  maj;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer, idles high like the line
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], RX_IN};
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_IN;
`endif

    // Third capture is the live line value, so the majority is known at the P/2+1 edge
    always_comb begin
        pre_sel = PRE_W'(8);
        if (Prescale == PRE_W'(16) || Prescale == PRE_W'(32)) pre_sel = Prescale;
        last_cnt = CNT_W'(pre_q - PRE_W'(1));
        mid_cnt  = CNT_W'(pre_q >> 1);
        lo_cnt   = mid_cnt - CNT_W'(1);
        hi_cnt   = mid_cnt + CNT_W'(1);
        wrap     = (edge_cnt == last_cnt);
        maj      = (samp0 & samp1) | (samp0 & rx) | (samp1 & rx);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            pre_q      <= PRE_W'(8);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail   <= 1'b0;
            stp_fail   <= 1'b0;
            samp0      <= 1'b1;
            samp1      <= 1'b1;
            shreg      <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state != IDLE) edge_cnt <= wrap ? '0 : edge_cnt + CNT_W'(1);
            if (edge_cnt == lo_cnt)  samp0 <= rx;
            if (edge_cnt == mid_cnt) samp1 <= rx;

            unique case (state)
                IDLE: begin
                    if (!rx) begin
                        state     <= START;
                        edge_cnt  <= '0;
                        bit_cnt   <= '0;
                        pre_q     <= pre_sel;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_fail  <= 1'b0;
                        stp_fail  <= 1'b0;
                    end
                end
                START: begin
                    if (edge_cnt == hi_cnt && maj) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (wrap) begin
                        state   <= DATA;
                        bit_cnt <= BIT_W'(1);
                    end
                end
                DATA: begin
                    if (edge_cnt == hi_cnt) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
                    if (wrap) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(DATA_WIDTH)) state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (edge_cnt == hi_cnt) par_fail <= (maj != ((^shreg) ^ par_typ_q));
                    if (wrap) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (edge_cnt == hi_cnt) stp_fail <= ~maj;
                    if (wrap) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        PAR_ERR <= par_fail;
                        STP_ERR <= stp_fail;
                        if (!par_fail && !stp_fail) begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= shreg;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the system UART. Oversamples the asynchronous serial line RX_IN at Prescale × baud rate in the UART clock domain, detects and qualifies the start bit, and majority-samples each bit at mid-bit. It deserializes LSB-first data, checks the optional parity bit and the stop bit, and presents the received byte as P_DATA with a one-cycle DATA_VALID strobe to the downstream data synchronizer. Frame format and parity settings are shared with the UART transmitter through the register file.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- CLK  in  1  UART oversampling clock.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line; idles high.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- Prescale  in  6  oversampling ratio; legal values are 8, 16 and 32. Any other value is treated as 8.
- P_DATA  out  DATA_WIDTH  last good received byte.
- DATA_VALID  out  1  one-cycle strobe marking a good frame.
- PAR_ERR  out  1  one-cycle strobe marking a parity mismatch.
- STP_ERR  out  1  one-cycle strobe marking a stop bit sampled as 0.

## Operation
- **Reset values:** all outputs 0; state IDLE; edge_cnt 0; bit_cnt 0.
- **Counters:**
  - edge_cnt runs 0..Prescale-1 within each bit period and wraps to 0.
  - bit_cnt advances on each wrap.
- **Sampling:** RX_IN is captured when edge_cnt equals P/2-1, P/2 and P/2+1, where P is Prescale. The sampled bit is the majority of these three captures and is valid from edge_cnt = P/2+2.
- **Configuration latch:** PAR_EN, PAR_TYP and Prescale are latched on the IDLE→START transition. Changes during a frame are ignored.
- **IDLE:** when RX_IN is 0 at a clock edge, go to START with edge_cnt = 0.
- **START:**
  - If the sampled bit is 1, the start bit is a glitch: return to IDLE at the next edge with no outputs.
  - If the sampled bit is 0, go to DATA at the edge_cnt wrap.
- **DATA:**
  - Each sampled bit shifts into the shift register LSB-first.
  - After DATA_WIDTH bits, go to PARITY if PAR_EN = 1, otherwise to STOP.
- **PARITY:** the expected parity is the XOR of the data bits XOR PAR_TYP. A mismatch with the sampled bit sets an internal par_fail flag.
- **STOP:** a sampled 0 sets an internal stp_fail flag. At edge_cnt = P-1, go to IDLE and register the outputs:
  - PAR_ERR = par_fail.
  - STP_ERR = stp_fail.
  - If neither flag is set: DATA_VALID = 1 and P_DATA = shift register.
- **Error handling:** on any error, P_DATA keeps its previous value.
- **Output lifetimes:**
  - PAR_ERR and STP_ERR can assert together.
  - All strobes last exactly one cycle.
  - P_DATA is held until the next good frame.

## Timing
- **Frame length:** with the START entry at edge T0, a frame occupies N×P cycles, where N = 10 without parity and 11 with parity.
- **Output cycle:** the strobes are high during cycle T0 + N×P.
- **Back-to-back frames:** after STOP→IDLE, a falling edge seen at the first IDLE cycle starts the next frame.
  - This costs at most one cycle of sample-point shift per frame.
  - It is tolerated because sampling is at mid-bit.
- **Glitch rejection:** a low pulse shorter than P/2-1 cycles is rejected. The block is back in IDLE at T0 + P/2+2.
- **Reset mid-frame:** RST low forces IDLE and clears all counters and outputs immediately. No strobe fires for the partial frame.
- **No backpressure:** the consumer must accept DATA_VALID in the cycle it is asserted.

## Configuration
- **UART_RX_SYNC_EN defined:**
  - RX_IN passes through a two-flop synchronizer, reset to 1, before all logic.
  - All latencies in Timing grow by 2 cycles relative to the pin.
- **UART_RX_SYNC_EN undefined:**
  - RX_IN is used directly.
  - The integrator guarantees RX_IN is already synchronous to CLK.

## Test plan
- **Good frame, no parity:** P=8, PAR_EN=0, send 0xA5 with stop 1 → DATA_VALID for one cycle at T0+80, P_DATA=0xA5, PAR_ERR=STP_ERR=0.
- **Good frame, even parity:** P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → DATA_VALID at T0+176, P_DATA=0x3C.
- **Parity error:** P=16, odd parity, send 0x3C with parity 0 → PAR_ERR=1 for one cycle, DATA_VALID=0, P_DATA unchanged.
- **Stop error plus glitch start:**
  - Send 0x55 with stop bit 0 → STP_ERR=1 for one cycle, DATA_VALID=0.
  - Then a 2-cycle low pulse at P=8 → no strobes, block in IDLE by T0+6.
- **Back-to-back frames:** P=32, frames 0x01 then 0xFE with no idle gap → two DATA_VALID pulses 320 or 321 cycles apart, with P_DATA 0x01 then 0xFE.
- **Reset mid-frame:** assert RST during bit 4 of a frame → all outputs 0. The following clean 0x81 frame is received correctly.
